mc_control_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32I-subset core: drives instruction fetch, decode, ALU execute,

---
 rtl/mc_control_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle sequencer for the RV32I-subset core: steps each instruction through
// fetch, decode, execute, memory access and writeback, and selects the ALU function.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        ab_we,
  output logic [4:0]  alu_func,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        trap,
  output logic [2:0]  state
);

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_AND   = 5'd3;
  localparam logic [4:0] ALU_OR    = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_ADDI  = 5'd6;
  localparam logic [4:0] ALU_ANDI  = 5'd7;
  localparam logic [4:0] ALU_ORI   = 5'd8;
  localparam logic [4:0] ALU_XORI  = 5'd9;
  localparam logic [4:0] ALU_LOAD  = 5'd10;
  localparam logic [4:0] ALU_STORE = 5'd11;
  localparam logic [4:0] ALU_BEQ   = 5'd12;
  localparam logic [4:0] ALU_BNE   = 5'd13;
  localparam logic [4:0] ALU_BLT   = 5'd14;
  localparam logic [4:0] ALU_BGE   = 5'd15;
  localparam logic [4:0] ALU_LUI   = 5'd16;
  localparam logic [4:0] ALU_JUMP  = 5'd17;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL} cls_t;

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_wait_cnt;
  cls_t             r_cls, w_dec_cls;
  logic [4:0]       r_func, w_dec_func;
  logic             r_rd_zero;
  logic             w_dec_legal;
  logic             w_timeout, w_mem_wait;
  logic             w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_ab_we;
  logic             w_reg_we, w_pc_we, w_pc_sel, w_trap;
  logic [4:0]       w_alu_func;
  logic [1:0]       w_wb_sel;
  logic [6:0]       w_opcode, w_funct7;
  logic [2:0]       w_funct3;
  logic             w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_unused = ^instr[24:15];

  always_comb begin
    w_dec_legal = 1'b0;
    w_dec_cls   = C_ALU;
    w_dec_func  = ALU_NOP;
    case (w_opcode)
      7'b0110011: begin
        case (w_funct3)
          3'b000: begin
            if (w_funct7 == 7'b0000000) begin w_dec_legal = 1'b1; w_dec_func = ALU_ADD; end
            else if (w_funct7 == 7'b0100000) begin w_dec_legal = 1'b1; w_dec_func = ALU_SUB; end
          end
          3'b111: if (w_funct7 == 7'b0) begin w_dec_legal = 1'b1; w_dec_func = ALU_AND; end
          3'b110: if (w_funct7 == 7'b0) begin w_dec_legal = 1'b1; w_dec_func = ALU_OR; end
          3'b100: if (w_funct7 == 7'b0) begin w_dec_legal = 1'b1; w_dec_func = ALU_XOR; end
          default: ;
        endcase
      end
      7'b0010011: begin
        case (w_funct3)
          3'b000: begin w_dec_legal = 1'b1; w_dec_func = ALU_ADDI; end
          3'b111: begin w_dec_legal = 1'b1; w_dec_func = ALU_ANDI; end
          3'b110: begin w_dec_legal = 1'b1; w_dec_func = ALU_ORI; end
          3'b100: begin w_dec_legal = 1'b1; w_dec_func = ALU_XORI; end
          default: ;
        endcase
      end
      7'b0000011: if (w_funct3 == 3'b010) begin
        w_dec_legal = 1'b1; w_dec_cls = C_LOAD; w_dec_func = ALU_LOAD;
      end
      7'b0100011: if (w_funct3 == 3'b010) begin
        w_dec_legal = 1'b1; w_dec_cls = C_STORE; w_dec_func = ALU_STORE;
      end
      7'b1100011: begin
        w_dec_cls = C_BRANCH;
        case (w_funct3)
          3'b000: begin w_dec_legal = 1'b1; w_dec_func = ALU_BEQ; end
          3'b001: begin w_dec_legal = 1'b1; w_dec_func = ALU_BNE; end
          3'b100: begin w_dec_legal = 1'b1; w_dec_func = ALU_BLT; end
          3'b101: begin w_dec_legal = 1'b1; w_dec_func = ALU_BGE; end
          default: ;
        endcase
      end
      7'b0110111: begin w_dec_legal = 1'b1; w_dec_func = ALU_LUI; end
      7'b1101111: begin w_dec_legal = 1'b1; w_dec_cls = C_JAL; w_dec_func = ALU_JUMP; end
      default: ;
    endcase
  end

  // The counter value seen on the Nth unanswered request cycle is N-1.
  assign w_timeout  = (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign w_mem_wait = w_mem_req && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_cls      <= C_ALU;
      r_func     <= ALU_NOP;
      r_rd_zero  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) r_wait_cnt <= '0;
      else if (w_mem_wait)         r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (r_state == S_DECODE) begin
        r_cls     <= w_dec_cls;
        r_func    <= w_dec_func;
        r_rd_zero <= (instr[11:7] == 5'd0);
      end
    end
  end

  // Only ir_we and the store-retire pc_we are qualified by mem_ready; the request
  // side (mem_req/mem_we/addr_sel) depends on registered state alone.
  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_addr_sel   = 1'b0;
    w_ir_we      = 1'b0;
    w_ab_we      = 1'b0;
    w_alu_func   = ALU_NOP;
    w_reg_we     = 1'b0;
    w_wb_sel     = 2'd0;
    w_pc_we      = 1'b0;
    w_pc_sel     = 1'b0;
    w_trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_we      = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
        end
      end
      S_DECODE: begin
        w_ab_we      = 1'b1;
        w_next_state = w_dec_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        w_alu_func = r_func;
        case (r_cls)
          C_BRANCH: begin
            w_pc_we      = 1'b1;
            w_pc_sel     = branch_taken;
            w_next_state = S_FETCH;
          end
          C_LOAD, C_STORE: w_next_state = S_MEM;
          default:         w_next_state = S_WB;
        endcase
      end
      S_MEM: begin
        w_alu_func = r_func;
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = (r_cls == C_STORE);
        if (mem_ready) begin
          if (r_cls == C_STORE) begin
            w_pc_we      = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
        end
      end
      S_WB: begin
        w_alu_func   = r_func;
        w_reg_we     = !r_rd_zero;
        w_wb_sel     = (r_cls == C_LOAD) ? 2'd1 : (r_cls == C_JAL) ? 2'd2 : 2'd0;
        w_pc_we      = 1'b1;
        w_pc_sel     = (r_cls == C_JAL);
        w_next_state = S_FETCH;
      end
      S_TRAP:  w_trap = 1'b1;
      default: w_next_state = S_TRAP;
    endcase
  end

  // Gating with rst_n makes every output drop the moment reset asserts, even mid-cycle.
  assign mem_req  = rst_n & w_mem_req;
  assign mem_we   = rst_n & w_mem_we;
  assign addr_sel = rst_n & w_addr_sel;
  assign ir_we    = rst_n & w_ir_we;
  assign ab_we    = rst_n & w_ab_we;
  assign alu_func = rst_n ? w_alu_func : ALU_NOP;
  assign reg_we   = rst_n & w_reg_we;
  assign wb_sel   = rst_n ? w_wb_sel : 2'd0;
  assign pc_we    = rst_n & w_pc_we;
  assign pc_sel   = rst_n & w_pc_sel;
  assign trap     = rst_n & w_trap;
  assign state    = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each instruction is expanded into a per-cycle expected
// schedule from its class and the chosen memory wait times, then replayed on the DUT.
module tb_mc_control_fsm;

  localparam int TO = 16;

  localparam logic [4:0] A_NOP = 5'd0,  A_ADD = 5'd1,  A_SUB = 5'd2,   A_AND = 5'd3;
  localparam logic [4:0] A_OR  = 5'd4,  A_XOR = 5'd5,  A_ADDI = 5'd6,  A_ANDI = 5'd7;
  localparam logic [4:0] A_ORI = 5'd8,  A_XORI = 5'd9, A_LOAD = 5'd10, A_STORE = 5'd11;
  localparam logic [4:0] A_BEQ = 5'd12, A_BNE = 5'd13, A_BLT = 5'd14,  A_BGE = 5'd15;
  localparam logic [4:0] A_LUI = 5'd16, A_JUMP = 5'd17;

  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_T = 3'd7;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        branch_taken, mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_we, ab_we, reg_we, pc_we, pc_sel, trap;
  logic [4:0]  alu_func;
  logic [1:0]  wb_sel;
  logic [2:0]  state;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .ab_we(ab_we), .alu_func(alu_func), .reg_we(reg_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .trap(trap), .state(state)
  );

  typedef struct packed {
    logic       rdy;
    logic       br;
    logic [2:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       ab_we;
    logic [4:0] func;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic       pc_sel;
    logic       trap;
  } cyc_t;

  cyc_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_no, got, exp);
    end
  endtask

  function automatic cyc_t rec(input logic [2:0] st);
    cyc_t e;
    e     = '0;
    e.st  = st;
    e.rdy = 1'($urandom_range(0, 1));
    e.br  = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic check_rec(input cyc_t e);
    chk("state",    32'(state),    32'(e.st));
    chk("mem_req",  32'(mem_req),  32'(e.mem_req));
    chk("mem_we",   32'(mem_we),   32'(e.mem_we));
    chk("addr_sel", 32'(addr_sel), 32'(e.addr_sel));
    chk("ir_we",    32'(ir_we),    32'(e.ir_we));
    chk("ab_we",    32'(ab_we),    32'(e.ab_we));
    chk("alu_func", 32'(alu_func), 32'(e.func));
    chk("reg_we",   32'(reg_we),   32'(e.reg_we));
    chk("wb_sel",   32'(wb_sel),   32'(e.wb_sel));
    chk("pc_we",    32'(pc_we),    32'(e.pc_we));
    chk("pc_sel",   32'(pc_sel),   32'(e.pc_sel));
    chk("trap",     32'(trap),     32'(e.trap));
  endtask

  // Asserts reset mid-cycle with mem_ready/branch_taken high, checks everything is
  // quiet at once and one edge later, then releases away from the clock edge.
  task automatic reset_pulse();
    cyc_t z;
    z = '0;
    mem_ready    = 1'b1;
    branch_taken = 1'b1;
    rst_n        = 1'b0;
    #1;
    check_rec(z);
    @(posedge clk);
    #1;
    check_rec(z);
    rst_n = 1'b1;
  endtask

  // Builds the expected schedule for one request phase (fetch or memory access).
  task automatic push_req(input logic [2:0] st, input int w, input bit store,
                          input logic [4:0] func, output bit timed_out);
    cyc_t e;
    timed_out = (w >= TO);
    for (int i = 0; i < (timed_out ? TO : w + 1); i++) begin
      e          = rec(st);
      e.rdy      = (!timed_out && i == w);
      e.mem_req  = 1'b1;
      e.addr_sel = (st == ST_M);
      e.mem_we   = (st == ST_M) && store;
      e.func     = (st == ST_M) ? func : A_NOP;
      e.ir_we    = (st == ST_F) && e.rdy;
      e.pc_we    = (st == ST_M) && store && e.rdy;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input int kind, input logic [4:0] func,
                           input int fw, input int mw, input bit bt, input int rst_at);
    cyc_t e;
    bit   trapped, hit;
    int   idx;
    exp_q.delete();
    instr = ins;
    push_req(ST_F, fw, 1'b0, A_NOP, trapped);
    if (!trapped) begin
      e = rec(ST_D);
      e.ab_we = 1'b1;
      exp_q.push_back(e);
      if (kind == K_ILL) trapped = 1'b1;
    end
    if (!trapped) begin
      e = rec(ST_E);
      e.func = func;
      if (kind == K_BR) begin
        e.br     = bt;
        e.pc_we  = 1'b1;
        e.pc_sel = bt;
      end
      exp_q.push_back(e);
      if (kind == K_LOAD || kind == K_STORE)
        push_req(ST_M, mw, kind == K_STORE, func, trapped);
      if (!trapped && kind != K_BR && kind != K_STORE) begin
        e        = rec(ST_W);
        e.func   = func;
        e.reg_we = (ins[11:7] != 5'd0);
        e.wb_sel = (kind == K_LOAD) ? 2'd1 : (kind == K_JAL) ? 2'd2 : 2'd0;
        e.pc_we  = 1'b1;
        e.pc_sel = (kind == K_JAL);
        exp_q.push_back(e);
      end
    end
    if (trapped) begin
      for (int i = 0; i < 3; i++) begin
        e = rec(ST_T);
        e.trap = 1'b1;
        exp_q.push_back(e);
      end
    end
    idx = 0;
    hit = 1'b0;
    while (exp_q.size() > 0 && !hit) begin
      e            = exp_q.pop_front();
      mem_ready    = e.rdy;
      branch_taken = e.br;
      @(negedge clk);
      check_rec(e);
      if (idx == rst_at) begin
        #1;
        reset_pulse();
        hit = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        cyc_no++;
      end
      idx++;
    end
    if (trapped && !hit) begin
      #2;
      reset_pulse();
    end
  endtask

  // Encodes instruction m of a mnemonic table; the expected class and ALU code come
  // from the table, not from decoding the bits.
  task automatic make_instr(input int m, output logic [31:0] ins, output int kind,
                            output logic [4:0] func);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit         set_f3, set_f7;
    ins = $urandom;
    if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
    opc = 7'h33; f3 = 3'b000; f7 = 7'h00; set_f3 = 1'b1; set_f7 = 1'b0;
    kind = K_ALU; func = A_NOP;
    case (m)
      0:  begin set_f7 = 1'b1; func = A_ADD; end
      1:  begin set_f7 = 1'b1; f7 = 7'h20; func = A_SUB; end
      2:  begin set_f7 = 1'b1; f3 = 3'b111; func = A_AND; end
      3:  begin set_f7 = 1'b1; f3 = 3'b110; func = A_OR; end
      4:  begin set_f7 = 1'b1; f3 = 3'b100; func = A_XOR; end
      5:  begin opc = 7'h13; func = A_ADDI; end
      6:  begin opc = 7'h13; f3 = 3'b111; func = A_ANDI; end
      7:  begin opc = 7'h13; f3 = 3'b110; func = A_ORI; end
      8:  begin opc = 7'h13; f3 = 3'b100; func = A_XORI; end
      9:  begin opc = 7'h03; f3 = 3'b010; kind = K_LOAD; func = A_LOAD; end
      10: begin opc = 7'h23; f3 = 3'b010; kind = K_STORE; func = A_STORE; end
      11: begin opc = 7'h63; f3 = 3'b000; kind = K_BR; func = A_BEQ; end
      12: begin opc = 7'h63; f3 = 3'b001; kind = K_BR; func = A_BNE; end
      13: begin opc = 7'h63; f3 = 3'b100; kind = K_BR; func = A_BLT; end
      14: begin opc = 7'h63; f3 = 3'b101; kind = K_BR; func = A_BGE; end
      15: begin opc = 7'h37; set_f3 = 1'b0; func = A_LUI; end
      16: begin opc = 7'h6F; set_f3 = 1'b0; kind = K_JAL; func = A_JUMP; end
      17: begin opc = 7'h7F; set_f3 = 1'b0; kind = K_ILL; end
      18: begin set_f7 = 1'b1; f3 = 3'b001; kind = K_ILL; end
      19: begin set_f7 = 1'b1; f7 = 7'h01; kind = K_ILL; end
      20: begin opc = 7'h13; f3 = 3'b010; kind = K_ILL; end
      21: begin opc = 7'h03; f3 = 3'b000; kind = K_ILL; end
      22: begin opc = 7'h23; f3 = 3'b000; kind = K_ILL; end
      23: begin opc = 7'h63; f3 = 3'b110; kind = K_ILL; end
      default: begin opc = 7'h17; set_f3 = 1'b0; kind = K_ILL; end
    endcase
    ins[6:0] = opc;
    if (set_f3) ins[14:12] = f3;
    if (set_f7) ins[31:25] = f7;
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 70) return int'($urandom_range(0, 3));
    if (r < 85) return int'($urandom_range(4, TO - 2));
    if (r < 95) return TO - 1;
    return TO;
  endfunction

  initial begin
    logic [31:0] ins;
    int          kind;
    logic [4:0]  func;
    rst_n        = 1'b0;
    instr        = '0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_pulse();

    run_instr(32'h00500093, K_ALU, A_ADDI, 0, 0, 1'b0, -1);
    make_instr(11, ins, kind, func);
    run_instr(ins, kind, func, 0, 0, 1'b1, -1);
    make_instr(9, ins, kind, func);
    run_instr(ins, kind, func, 0, 3, 1'b0, -1);
    make_instr(10, ins, kind, func);
    run_instr(ins, kind, func, 1, 0, 1'b0, -1);
    run_instr(32'h008000EF, K_JAL, A_JUMP, 0, 0, 1'b0, -1);
    run_instr(32'h0000007F, K_ILL, A_NOP, 0, 0, 1'b0, -1);
    run_instr(32'h00500093, K_ALU, A_ADDI, TO, 0, 1'b0, -1);
    run_instr(32'h00500093, K_ALU, A_ADDI, TO - 1, 0, 1'b0, -1);
    make_instr(9, ins, kind, func);
    run_instr(ins, kind, func, 0, TO, 1'b0, -1);
    make_instr(10, ins, kind, func);
    run_instr(ins, kind, func, 0, TO - 1, 1'b0, -1);
    make_instr(9, ins, kind, func);
    run_instr(ins, kind, func, 0, 3, 1'b0, 4);
    run_instr(32'h00500093, K_ALU, A_ADDI, 0, 0, 1'b0, -1);

    for (int n = 0; n < 300; n++) begin
      make_instr(int'($urandom_range(0, 24)), ins, kind, func);
      run_instr(ins, kind, func, pick_wait(), pick_wait(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
